// File: rtl/cs_pkg.sv
// rtl/cs_pkg.sv - shared constants, FSM state type and LFSR step for the loopback BIST
package cs_pkg;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;      // x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [31:0] MISR_TAPS = 32'h8020_0003; // bits 31, 21, 1, 0

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } cs_bist_state_e;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/cs_bist_fifo.sv
// rtl/cs_bist_fifo.sv - expected-value FIFO; push while full is accepted when a pop frees a slot
module cs_bist_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_q];

  always_ff @(posedge aclk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn || clr) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/cs_loopback_bist.sv
// rtl/cs_loopback_bist.sv - encoder/decoder loopback BIST with MISR signature
// Optional CS_BIST_ERR_INJECT_EN adds err_inject/inj_idx to corrupt one expected entry.
module cs_loopback_bist
  import cs_pkg::*;
#(
  parameter int          K          = 5,
  parameter int          M          = 3,
  parameter int          L          = 11,
  parameter logic [15:0] SEED       = 16'h0001,
  parameter int          FIFO_DEPTH = 4,
  parameter int          TIMEOUT    = 1024
) (
  input  logic                 aclk,
  input  logic                 aresetn,
`ifdef CS_BIST_ERR_INJECT_EN
  input  logic                 err_inject,
  input  logic [15:0]          inj_idx,
`endif
  input  logic                 start,
  input  logic [15:0]          num_vectors,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic [15:0]          err_count,
  output logic [31:0]          signature,
  output logic                 enc_in_valid,
  input  logic                 enc_in_ready,
  output logic [M*(L-1)-1:0]   enc_din,
  input  logic                 enc_out_valid,
  input  logic [K*(L-1)-1:0]   enc_dout,
  output logic                 dec_in_valid,
  input  logic                 dec_in_ready,
  output logic [K*(L-1)-1:0]   dec_din,
  input  logic                 dec_out_valid,
  input  logic [M*(L-1)-1:0]   dec_dout
);

  localparam int W   = L - 1;
  localparam int EW  = M * W;
  localparam int CW  = K * W;
  localparam int NCH = (EW + 31) / 32;
  localparam int WDW = $clog2(TIMEOUT + 1);

  cs_bist_state_e state_q, state_d;
  logic [15:0]    nv_q, nv_d, issued_q, issued_d, compared_q, compared_d, err_q, err_d;
  logic [31:0]    sig_q, sig_d;
  logic [15:0]    lfsr_q, lfsr_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic           hold_full_q, hold_full_d, overflow_q, overflow_d;
  logic           timeout_q, timeout_d, pass_q, pass_d;
  logic [CW-1:0]  hold_q, hold_d;

  logic           in_run, hold_drain, enc_hs, fifo_pop, fifo_clr, fifo_full, fifo_empty;
  logic [EW-1:0]  words, push_data, fifo_dout;
  logic [NCH*32-1:0] padded;
  logic [31:0]    fold;

  assign in_run       = (state_q == ST_RUN);
  assign busy         = in_run || (state_q == ST_DRAIN);
  assign done         = (state_q == ST_DONE);
  assign hold_drain   = hold_full_q && dec_in_ready;
  assign enc_in_valid = in_run && (issued_q < nv_q) && !fifo_full && (!hold_full_q || hold_drain);
  assign enc_hs       = enc_in_valid && enc_in_ready;
  assign fifo_pop     = busy && dec_out_valid && !fifo_empty;
  assign enc_din      = in_run ? words : '0;
  assign dec_in_valid = hold_full_q;
  assign dec_din      = hold_q;
  assign pass         = pass_q;
  assign timeout      = timeout_q;
  assign err_count    = err_q;
  assign signature    = sig_q;

  always_comb begin
    words = '0;
    for (int i = 0; i < M; i++) words[i*W +: W] = lfsr_q[W-1:0] ^ W'(i);
    push_data = words;
`ifdef CS_BIST_ERR_INJECT_EN
    if (err_inject && (issued_q == inj_idx)) push_data[0] = ~words[0];
`endif
  end

  always_comb begin
    padded = '0;
    padded[EW-1:0] = dec_dout;
    fold = '0;
    for (int c = 0; c < NCH; c++) fold = fold ^ padded[c*32 +: 32];
  end

  cs_bist_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .aclk(aclk), .aresetn(aresetn), .clr(fifo_clr), .push(enc_hs), .din(push_data),
    .pop(fifo_pop), .dout(fifo_dout), .full(fifo_full), .empty(fifo_empty)
  );

  always_comb begin
    state_d = state_q;  nv_d = nv_q;  issued_d = issued_q;  compared_d = compared_q;
    err_d = err_q;  sig_d = sig_q;  lfsr_d = lfsr_q;  wd_d = wd_q;
    hold_full_d = hold_full_q;  hold_d = hold_q;  overflow_d = overflow_q;
    timeout_d = timeout_q;  pass_d = pass_q;  fifo_clr = 1'b0;

    if (busy) begin
      if (enc_hs) begin
        issued_d = issued_q + 16'd1;
        lfsr_d   = lfsr_next(lfsr_q);
      end
      // A full, non-draining hold register drops the new word and flags it
      if (enc_out_valid) begin
        if (!hold_full_q || hold_drain) begin
          hold_full_d = 1'b1;
          hold_d      = enc_dout;
        end else begin
          overflow_d = 1'b1;
        end
      end else if (hold_drain) begin
        hold_full_d = 1'b0;
      end
      if (dec_out_valid) begin
        sig_d = {sig_q[30:0], ^(sig_q & MISR_TAPS)} ^ fold;
        wd_d  = '0;
        if (fifo_empty || (dec_dout != fifo_dout))
          err_d = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
        if (!fifo_empty) compared_d = compared_q + 16'd1;
      end else if (state_q == ST_DRAIN) begin
        wd_d = wd_q + 1'b1;
      end
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          nv_d = num_vectors;  issued_d = '0;  compared_d = '0;  err_d = '0;
          sig_d = '0;  lfsr_d = SEED;  wd_d = '0;  hold_full_d = 1'b0;  hold_d = '0;
          overflow_d = 1'b0;  timeout_d = 1'b0;  fifo_clr = 1'b1;
          pass_d  = (num_vectors == 16'd0);
          state_d = (num_vectors == 16'd0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (issued_d == nv_q) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (compared_q == nv_q) begin
          state_d = ST_DONE;
          pass_d  = (err_d == 16'd0) && !overflow_d && !timeout_q;
        end else if (!dec_out_valid && (wd_q == WDW'(TIMEOUT - 1))) begin
          state_d   = ST_DONE;
          timeout_d = 1'b1;
          pass_d    = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;  nv_q <= '0;  issued_q <= '0;  compared_q <= '0;
      err_q <= '0;  sig_q <= '0;  lfsr_q <= SEED;  wd_q <= '0;
      hold_full_q <= 1'b0;  hold_q <= '0;  overflow_q <= 1'b0;
      timeout_q <= 1'b0;  pass_q <= 1'b0;
    end else begin
      state_q <= state_d;  nv_q <= nv_d;  issued_q <= issued_d;  compared_q <= compared_d;
      err_q <= err_d;  sig_q <= sig_d;  lfsr_q <= lfsr_d;  wd_q <= wd_d;
      hold_full_q <= hold_full_d;  hold_q <= hold_d;  overflow_q <= overflow_d;
      timeout_q <= timeout_d;  pass_q <= pass_d;
    end
  end

endmodule

// File: tb/tb_cs_loopback_bist.sv
// tb/tb_cs_loopback_bist.sv - scoreboard bench for cs_loopback_bist with loopback codec models
module tb_cs_loopback_bist;

  localparam int K = 5, M = 3, L = 11, W = L - 1, EW = M * W, CW = K * W;
  localparam int TIMEOUT = 1024;
  localparam logic [15:0] SEED_TB = 16'h0001;

  typedef struct {
    logic        pass;
    logic [15:0] err;
    logic        to;
    logic [31:0] sig;
  } res_t;

  logic aclk, aresetn, start;
  logic [15:0] num_vectors;
  logic busy, done, pass, timeout;
  logic [15:0] err_count;
  logic [31:0] signature;
  logic enc_in_valid, enc_in_ready, enc_out_valid;
  logic [EW-1:0] enc_din;
  logic [CW-1:0] enc_dout;
  logic dec_in_valid, dec_in_ready, dec_out_valid;
  logic [CW-1:0] dec_din;
  logic [EW-1:0] dec_dout;
`ifdef CS_BIST_ERR_INJECT_EN
  logic err_inject = 1'b0;
  logic [15:0] inj_idx = '0;
`endif

  int n_checks = 0, n_pass = 0;
  int cyc = 0, done_cyc = 0, last_dov_cyc = 0;
  int hs_count = 0, env_cycles = 0, results_seen = 0;
  int stop_after = 0, cor_a = -1, cor_b = -1, dec_seen = 0;
  bit stall_en = 0, pend_v = 0;
  logic [EW-1:0] pend_d = '0;
  logic done_prev = 1'b0;
  logic [EW-1:0] exp_vec[$];
  res_t res_q[$];

  cs_loopback_bist dut (
    .aclk(aclk), .aresetn(aresetn),
`ifdef CS_BIST_ERR_INJECT_EN
    .err_inject(err_inject), .inj_idx(inj_idx),
`endif
    .start(start), .num_vectors(num_vectors), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .err_count(err_count), .signature(signature),
    .enc_in_valid(enc_in_valid), .enc_in_ready(enc_in_ready), .enc_din(enc_din),
    .enc_out_valid(enc_out_valid), .enc_dout(enc_dout),
    .dec_in_valid(dec_in_valid), .dec_in_ready(dec_in_ready), .dec_din(dec_din),
    .dec_out_valid(dec_out_valid), .dec_dout(dec_dout)
  );

  // Systematic toy code: data words, their XOR, and the inverted first word
  assign enc_out_valid = enc_in_valid && enc_in_ready;
  assign enc_dout = {~enc_din[W-1:0], enc_din[0 +: W] ^ enc_din[W +: W] ^ enc_din[2*W +: W], enc_din};

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, got, exp);
  endtask

  task automatic step();
    @(posedge aclk);
    #3;
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic [15:0] fb;
    fb = (s >> 15) ^ (s >> 13) ^ (s >> 12) ^ (s >> 10);
    return {s[14:0], fb[0]};
  endfunction

  function automatic logic [EW-1:0] vec_of(input logic [15:0] s);
    logic [EW-1:0] v;
    for (int i = 0; i < M; i++) v[i*W +: W] = s[W-1:0] ^ W'(i);
    return v;
  endfunction

  function automatic logic [31:0] misr_step(input logic [31:0] sig, input logic [EW-1:0] d);
    logic [63:0] pad;
    logic [31:0] f;
    pad = 64'(d);
    f = '0;
    for (int c = 0; c < EW; c += 32) f = f ^ pad[c +: 32];
    return {sig[30:0], sig[31] ^ sig[21] ^ sig[1] ^ sig[0]} ^ f;
  endfunction

  // Reference model: loads the expected vector stream and returns the run outcome
  task automatic load_model(input int nv, input int stop_n, input int ca, input int cb,
                            input int inj, output res_t r);
    logic [15:0] s;
    logic [EW-1:0] v, o, e;
    int errs;
    s = SEED_TB;
    r.sig = '0;
    errs = 0;
    for (int k = 0; k < nv; k++) begin
      v = vec_of(s);
      exp_vec.push_back(v);
      e = v;
      if (k == inj) e[0] = ~e[0];
      o = v;
      if (k == ca || k == cb) o[W+3] = ~o[W+3];
      if (k < stop_n) begin
        r.sig = misr_step(r.sig, o);
        if (o != e) errs++;
      end
      s = lfsr_step(s);
    end
    r.to   = (stop_n < nv);
    r.err  = 16'(errs);
    r.pass = (errs == 0) && !r.to;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    start = 1'b0;
    repeat (2) step();
    exp_vec.delete();
    res_q.delete();
    pend_v = 0;
    dec_seen = 0;
    hs_count = 0;
    env_cycles = 0;
    last_dov_cyc = cyc;
    aresetn = 1'b1;
  endtask

  task automatic run_case(input string tag, input int nv, input int stop_n, input bit stall,
                          input int ca, input int cb, input int inj);
    res_t r;
    int seen0, t0, gap;
    do_reset();
    stall_en = stall;
    stop_after = stop_n;
    cor_a = ca;
    cor_b = cb;
`ifdef CS_BIST_ERR_INJECT_EN
    err_inject = (inj >= 0);
    inj_idx = 16'((inj < 0) ? 0 : inj);
`endif
    load_model(nv, stop_n, ca, cb, inj, r);
    res_q.push_back(r);
    seen0 = results_seen;
    num_vectors = 16'(nv);
    start = 1'b1;
    step();
    start = 1'b0;
    if (nv == 0) begin
      chk({tag, "_done_next_cycle"}, 64'(done), 64'd1);
      chk({tag, "_pass_next_cycle"}, 64'(pass), 64'd1);
    end
    t0 = 0;
    while (results_seen == seen0 && t0 < 20000) begin
      step();
      t0++;
    end
    chk({tag, "_finished"}, 64'(results_seen != seen0), 64'd1);
    chk({tag, "_vectors_issued"}, 64'(hs_count), 64'(nv));
    if (stop_n < nv) begin
      gap = done_cyc - last_dov_cyc;
      chk({tag, "_timeout_gap"}, 64'(gap >= TIMEOUT && gap <= TIMEOUT + 40), 64'd1);
    end
    if (nv == 0) begin
      repeat (4) step();
      chk({tag, "_no_enc_valid"}, 64'(env_cycles), 64'd0);
    end
  endtask

  // Drives readies and a one-cycle-latency decoder (optionally corrupting or going silent)
  initial begin
    enc_in_ready = 1'b0;
    dec_in_ready = 1'b0;
    dec_out_valid = 1'b0;
    dec_dout = '0;
    forever begin
      @(negedge aclk);
      dec_out_valid = pend_v;
      dec_dout = pend_v ? pend_d : '0;
      if (pend_v) last_dov_cyc = cyc;
      pend_v = 0;
      enc_in_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      dec_in_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (dec_in_valid && dec_in_ready) begin
        if (dec_seen < stop_after) begin
          pend_d = dec_din[EW-1:0];
          if (dec_seen == cor_a || dec_seen == cor_b) pend_d[W+3] = ~pend_d[W+3];
          pend_v = 1;
        end
        dec_seen++;
      end
    end
  end

  // Monitor: checks offered vectors against the model and run results at done
  initial begin
    res_t r;
    forever begin
      @(negedge aclk);
      #2;
      cyc++;
      if (enc_in_valid) begin
        env_cycles++;
        chk("enc_vec_avail", 64'(exp_vec.size() != 0), 64'd1);
        if (exp_vec.size() != 0) begin
          chk("enc_din", 64'(enc_din), 64'(exp_vec[0]));
          if (enc_in_ready) begin
            void'(exp_vec.pop_front());
            hs_count++;
          end
        end
      end
      if (done && !done_prev) begin
        if (res_q.size() == 0) begin
          chk("result_expected", 64'(res_q.size()), 64'd1);
        end else begin
          r = res_q.pop_front();
          chk("res_pass", 64'(pass), 64'(r.pass));
          chk("res_err_count", 64'(err_count), 64'(r.err));
          chk("res_timeout", 64'(timeout), 64'(r.to));
          chk("res_signature", 64'(signature), 64'(r.sig));
        end
        results_seen++;
        done_cyc = cyc;
      end
      done_prev = done;
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_pass"}, 64'(pass), 64'd0);
    chk({tag, "_timeout"}, 64'(timeout), 64'd0);
    chk({tag, "_enc_in_valid"}, 64'(enc_in_valid), 64'd0);
    chk({tag, "_dec_in_valid"}, 64'(dec_in_valid), 64'd0);
    chk({tag, "_err_count"}, 64'(err_count), 64'd0);
    chk({tag, "_signature"}, 64'(signature), 64'd0);
    chk({tag, "_enc_din"}, 64'(enc_din), 64'd0);
    chk({tag, "_dec_din"}, 64'(dec_din), 64'd0);
  endtask

  initial begin
    res_t r;
    aresetn = 1'b0;
    start = 1'b0;
    num_vectors = '0;
    do_reset();
    step();
    chk_reset_outputs("por");

    run_case("ideal100", 100, 100, 1'b0, -1, -1, -1);
    run_case("corrupt50", 50, 50, 1'b0, 10, 20, -1);
    run_case("stall1000", 1000, 1000, 1'b1, -1, -1, -1);
    run_case("dec_silent", 8, 5, 1'b0, -1, -1, -1);
    run_case("zero_vec", 0, 0, 1'b0, -1, -1, -1);
`ifdef CS_BIST_ERR_INJECT_EN
    run_case("inject7", 20, 20, 1'b0, -1, -1, 7);
    err_inject = 1'b0;
`endif

    do_reset();
    stall_en = 0;
    stop_after = 1000;
    cor_a = -1;
    cor_b = -1;
    load_model(1000, 1000, -1, -1, -1, r);
    num_vectors = 16'd1000;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (30) step();
    chk("midrun_busy_before_reset", 64'(busy), 64'd1);
    aresetn = 1'b0;
    step();
    chk_reset_outputs("midrun");
    do_reset();
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
